cla_shift_add_mul: RTL and testbench

- Sequential unsigned 32x32 -> 64-bit shift-add multiplier.
- Sits directly upstream of, and around, the team's 64-bit carry-lookahead adder (cla_64bit). It drives that adder's operands every cycle and registers its sum as the running partial product.
- One multiplication in flight at a time.
- valid/ready handshake on both the operand side and the product side.

---
 rtl/cla_shift_add_mul.sv | 174 +++++++++++++++++
 tb/tb_cla_shift_add_mul.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_shift_add_mul.sv
// Sequential 32x32->64 shift-add multiplier that drives a 64-bit carry-lookahead adder every cycle.
// Optional signed operands with CLA_MUL_SIGNED_EN (adds is_signed and a one-cycle NEG state).

module cla_64bit (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_cin,
    output logic [63:0] o_sum,
    output logic        o_cout
);
    logic [63:0] w_g, w_p, w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // 4-bit lookahead groups; group generate/propagate chains the group carries
    always_comb begin
        logic w_cg, w_gg, w_gp;
        w_c  = '0;
        w_cg = i_cin;
        for (int k = 0; k < 16; k++) begin
            w_c[4*k]   = w_cg;
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cg);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k]) | ((&w_p[4*k+1 -: 2]) & w_cg);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | ((&w_p[4*k+2 -: 2]) & w_g[4*k]) | ((&w_p[4*k+2 -: 3]) & w_cg);
            w_gg = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | ((&w_p[4*k+3 -: 2]) & w_g[4*k+1]) | ((&w_p[4*k+3 -: 3]) & w_g[4*k]);
            w_gp = &w_p[4*k+3 -: 4];
            w_cg = w_gg | (w_gp & w_cg);
        end
        o_cout = w_cg;
    end

    assign o_sum = w_p ^ w_c;
endmodule

module cla_shift_add_mul #(
    parameter int unsigned EARLY_TERM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef CLA_MUL_SIGNED_EN
    input  logic        is_signed,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);
`ifdef CLA_MUL_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_NEG = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t      r_state, w_state_nxt, w_run_exit;
    logic [63:0] r_acc, r_mcand, w_acc_nxt, w_mcand_nxt;
    logic [31:0] r_mplier, w_mplier_nxt, w_mag_a, w_mag_b;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [63:0] w_add_a, w_add_b, w_sum;
    logic        w_add_cin, w_cout, w_run, w_early_ok;

    // A carry out of the running sum cannot happen for 32x32 operands; pin to all-ones if it ever did
    function automatic logic [63:0] sat_u64(input logic [63:0] sum, input logic carry);
        return carry ? '1 : sum;
    endfunction

    assign w_early_ok = (EARLY_TERM != 0);

`ifdef CLA_MUL_SIGNED_EN
    logic r_neg, w_neg_nxt, w_sgn_a, w_sgn_b;
    assign w_sgn_a    = is_signed & a[31];
    assign w_sgn_b    = is_signed & b[31];
    assign w_mag_a    = w_sgn_a ? (~a + 32'd1) : a;
    assign w_mag_b    = w_sgn_b ? (~b + 32'd1) : b;
    assign w_run_exit = r_neg ? S_NEG : S_DONE;
`else
    assign w_mag_a    = a;
    assign w_mag_b    = b;
    assign w_run_exit = S_DONE;
`endif

    cla_64bit u_cla (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (w_add_cin),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_cnt_nxt    = r_cnt;
        w_add_a      = r_acc;
        w_add_b      = '0;
        w_add_cin    = 1'b0;
        w_run        = 1'b0;
`ifdef CLA_MUL_SIGNED_EN
        w_neg_nxt    = r_neg;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc_nxt    = '0;
                    w_mcand_nxt  = {32'b0, w_mag_a};
                    w_mplier_nxt = w_mag_b;
                    w_cnt_nxt    = '0;
`ifdef CLA_MUL_SIGNED_EN
                    w_neg_nxt    = w_sgn_a ^ w_sgn_b;
`endif
                    w_state_nxt  = (w_early_ok && w_mag_b == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_run        = 1'b1;
                w_add_b      = r_mplier[0] ? r_mcand : 64'b0;
                w_acc_nxt    = sat_u64(w_sum, w_cout);
                w_mcand_nxt  = {r_mcand[62:0], 1'b0};
                w_mplier_nxt = {1'b0, r_mplier[31:1]};
                w_cnt_nxt    = r_cnt + 5'd1;
                if (r_cnt == 5'd31 || (w_early_ok && r_mplier[31:1] == 31'd0))
                    w_state_nxt = w_run_exit;
            end
`ifdef CLA_MUL_SIGNED_EN
            S_NEG: begin
                w_add_a     = ~r_acc;
                w_add_cin   = 1'b1;
                w_acc_nxt   = w_sum;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`ifdef CLA_MUL_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= w_cnt_nxt;
`ifdef CLA_MUL_SIGNED_EN
            r_neg    <= w_neg_nxt;
`endif
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_acc;
endmodule

// File: tb/tb_cla_shift_add_mul.sv
// Self-checking bench for cla_shift_add_mul: dut0 runs EARLY_TERM=0, dut1 runs EARLY_TERM=1.
// Signed scenarios are compiled in when CLA_MUL_SIGNED_EN is defined.

module tb_cla_shift_add_mul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] op_a      [2];
    logic [31:0] op_b      [2];
    logic        sgn       [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] product   [2];
    logic        busy      [2];

    int n_chk = 0;
    int n_pass = 0;
    int cout_err = 0;
    int run_cycles = 0;

    cla_shift_add_mul #(.EARLY_TERM(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(op_a[0]), .b(op_b[0]),
`ifdef CLA_MUL_SIGNED_EN
        .is_signed(sgn[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(product[0]), .busy(busy[0])
    );

    cla_shift_add_mul #(.EARLY_TERM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(op_a[1]), .b(op_b[1]),
`ifdef CLA_MUL_SIGNED_EN
        .is_signed(sgn[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(product[1]), .busy(busy[1])
    );

    always @(negedge clk) begin
        if (dut0.w_run) begin
            run_cycles++;
            if (dut0.w_cout !== 1'b0) cout_err++;
        end
        if (dut1.w_run) begin
            run_cycles++;
            if (dut1.w_cout !== 1'b0) cout_err++;
        end
    end

    function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Edges from the accepting edge (counted as 1) to the edge that raises out_valid
    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y, input logic s, input bit et);
        logic [31:0] my;
        int n;
        bit neg;
        neg = s && (x[31] ^ y[31]);
        my  = (s && y[31]) ? -y : y;
        if (!et) n = 32;
        else begin
            n = 0;
            for (int i = 0; i < 32; i++) if (my[i]) n = i + 1;
        end
        return n + 1 + ((neg && n > 0) ? 1 : 0);
    endfunction

    task automatic do_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic s, input string tag);
        int lat, w, exp_l;
        logic [63:0] exp_p;
        exp_p = ref_product(x, y, s);
        exp_l = ref_latency(x, y, s, i == 1);
        @(negedge clk);
        w = 0;
        while (in_ready[i] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (in_ready[i] !== 1'b1) $display("FAIL %s_in_ready got=%b want=1", tag, in_ready[i]);
        else n_pass++;
        in_valid[i] = 1'b1; op_a[i] = x; op_b[i] = y; sgn[i] = s; out_ready[i] = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid[i] = 1'b0; op_a[i] = $urandom; op_b[i] = $urandom; sgn[i] = 1'($urandom_range(0, 1));
        while (out_valid[i] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_chk++;
        if (lat != exp_l) $display("FAIL %s_latency got=%0d want=%0d", tag, lat, exp_l);
        else n_pass++;
        n_chk++;
        if (product[i] !== exp_p) $display("FAIL %s_product got=%h want=%h", tag, product[i], exp_p);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_valid[i], in_ready[i]} !== 2'b01)
            $display("FAIL %s_handshake got valid/ready=%b%b want=01", tag, out_valid[i], in_ready[i]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; sgn[i] = 1'b0; out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (in_ready[i] !== 1'b1) $display("FAIL reset_in_ready%0d got=%b want=1", i, in_ready[i]);
            else n_pass++;
            n_chk++;
            if (out_valid[i] !== 1'b0) $display("FAIL reset_out_valid%0d got=%b want=0", i, out_valid[i]);
            else n_pass++;
            n_chk++;
            if (busy[i] !== 1'b0) $display("FAIL reset_busy%0d got=%b want=0", i, busy[i]);
            else n_pass++;
            n_chk++;
            if (product[i] !== 64'd0) $display("FAIL reset_product%0d got=%h want=0", i, product[i]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_range();
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "full_range");
    endtask

    task automatic test_early_term();
        do_op(1, 32'h1234_5678, 32'd5, 1'b0, "early_b5");
        do_op(1, $urandom, 32'd0, 1'b0, "early_b0");
        do_op(1, $urandom, 32'h8000_0000, 1'b0, "early_msb");
    endtask

    task automatic test_backpressure();
        int w;
        logic [63:0] exp_p;
        exp_p = ref_product(32'd7, 32'd6, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b1; op_a[0] = 32'd7; op_b[0] = 32'd6; sgn[0] = 1'b0; out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        w = 0;
        while (out_valid[0] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (out_valid[0] !== 1'b1) $display("FAIL bp_wait got out_valid=%b want=1", out_valid[0]);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = k[0]; op_a[0] = $urandom; op_b[0] = $urandom;
            @(posedge clk);
            @(negedge clk);
            n_chk++;
            if (product[0] !== exp_p) $display("FAIL bp_product got=%h want=%h", product[0], exp_p);
            else n_pass++;
            n_chk++;
            if ({out_valid[0], in_ready[0]} !== 2'b10)
                $display("FAIL bp_hold got valid/ready=%b%b want=10", out_valid[0], in_ready[0]);
            else n_pass++;
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010)
            $display("FAIL bp_release got valid/ready/busy=%b%b%b want=010", out_valid[0], in_ready[0], busy[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        in_valid[0] = 1'b1; op_a[0] = 32'd3; op_b[0] = 32'd3; sgn[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        n_chk++;
        if (busy[0] !== 1'b1) $display("FAIL midrst_busy_before got=%b want=1", busy[0]);
        else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_valid[0], busy[0], in_ready[0]} !== 3'b001)
            $display("FAIL midrst_state got valid/busy/ready=%b%b%b want=001", out_valid[0], busy[0], in_ready[0]);
        else n_pass++;
        n_chk++;
        if (product[0] !== 64'd0) $display("FAIL midrst_product got=%h want=0", product[0]);
        else n_pass++;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) seen++;
        end
        n_chk++;
        if (seen != 0) $display("FAIL midrst_no_output got=%0d want=0", seen);
        else n_pass++;
        do_op(0, 32'd2, 32'd9, 1'b0, "after_reset");
        // reset and a valid handshake on the same edge: reset must win
        @(negedge clk);
        rst_n = 1'b0; in_valid[0] = 1'b1; op_a[0] = 32'd5; op_b[0] = 32'd5;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy[0], in_ready[0]} !== 2'b01)
            $display("FAIL rst_vs_accept got busy/ready=%b%b want=01", busy[0], in_ready[0]);
        else n_pass++;
        in_valid[0] = 1'b0; rst_n = 1'b1;
    endtask

`ifdef CLA_MUL_SIGNED_EN
    task automatic test_signed();
        do_op(0, 32'hFFFF_FFFD, 32'd5, 1'b1, "signed_neg3x5");
        do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, "signed_min");
        do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, "unsigned_min");
        do_op(1, 32'hFFFF_FFFD, 32'd5, 1'b1, "signed_early");
        do_op(1, 32'd12, 32'hFFFF_FFF9, 1'b1, "signed_negb");
    endtask
`endif

    task automatic test_random();
        int i;
        logic [31:0] x, y;
        logic s;
        for (int n = 0; n < 20; n++) begin
            i = int'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
`ifdef CLA_MUL_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            do_op(i, x, y, s, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa [3];
        logic [31:0] xb [3];
        logic [63:0] got [$];
        int k, cyc, extra;
        bit acc;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) begin
                xa[j] = $urandom;
                xb[j] = $urandom >> $urandom_range(0, 28);
            end
            got.delete();
            k = 0; cyc = 0;
            out_ready[i] = 1'b1; sgn[i] = 1'b0;
            @(negedge clk);
            while ((k < 3 || got.size() < 3) && cyc < 400) begin
                if (out_valid[i] === 1'b1) got.push_back(product[i]);
                if (k < 3) begin
                    in_valid[i] = 1'b1; op_a[i] = xa[k]; op_b[i] = xb[k];
                end else in_valid[i] = 1'b0;
                acc = (k < 3) && (in_ready[i] === 1'b1);
                @(posedge clk);
                if (acc) k++;
                @(negedge clk);
                cyc++;
            end
            in_valid[i] = 1'b0;
            extra = 0;
            repeat (5) begin
                if (out_valid[i] === 1'b1) extra++;
                @(negedge clk);
            end
            n_chk++;
            if (got.size() + extra != 3) $display("FAIL b2b_count%0d got=%0d want=3", i, got.size() + extra);
            else n_pass++;
            for (int j = 0; j < 3; j++) begin
                n_chk++;
                if (j >= got.size()) $display("FAIL b2b_missing%0d_%0d got=none want=%h", i, j, ref_product(xa[j], xb[j], 1'b0));
                else if (got[j] !== ref_product(xa[j], xb[j], 1'b0))
                    $display("FAIL b2b_order%0d_%0d got=%h want=%h", i, j, got[j], ref_product(xa[j], xb[j], 1'b0));
                else n_pass++;
            end
        end
    endtask

    task automatic test_cout();
        n_chk++;
        if (run_cycles == 0) $display("FAIL cout_coverage got=%0d run cycles want>0", run_cycles);
        else n_pass++;
        n_chk++;
        if (cout_err != 0) $display("FAIL cout_in_run got=%0d cycles with carry want=0", cout_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_early_term();
        test_backpressure();
        test_reset_mid_run();
`ifdef CLA_MUL_SIGNED_EN
        test_signed();
`endif
        test_random();
        test_back_to_back();
        test_cout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
